// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped data cache controller.
package cache_pkg;

    localparam int unsigned WORD_W             = 32;
    localparam int unsigned BLOCK_W            = 128;
    localparam int unsigned OFFSET_W           = 2;
    localparam int unsigned DEFAULT_NUM_BLOCKS = 8;

    typedef enum logic [1:0] {
        StCompare,
        StWriteback,
        StAllocate
    } state_e;

    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0]  blk,
                                                   input logic [OFFSET_W-1:0] off);
        return blk[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_store.sv
// Valid/dirty/tag/data arrays: one read port, a word-write port and a block-fill port.
module cache_store
    import cache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = DEFAULT_NUM_BLOCKS,
    parameter int unsigned TAG_W      = 25,
    parameter int unsigned INDEX_W    = $clog2(NUM_BLOCKS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [INDEX_W-1:0]  rd_index_i,
    output logic                rd_valid_o,
    output logic                rd_dirty_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [BLOCK_W-1:0]  rd_block_o,
    input  logic                wr_en_i,
    input  logic [INDEX_W-1:0]  wr_index_i,
    input  logic [OFFSET_W-1:0] wr_offset_i,
    input  logic [WORD_W-1:0]   wr_word_i,
    input  logic                fill_en_i,
    input  logic [INDEX_W-1:0]  fill_index_i,
    input  logic [TAG_W-1:0]    fill_tag_i,
    input  logic [BLOCK_W-1:0]  fill_block_i
);

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en_i) begin
            valid_d[fill_index_i] = 1'b1;
            dirty_d[fill_index_i] = 1'b0;
        end else if (wr_en_i) begin
            dirty_d[wr_index_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and block data carry no reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[fill_index_i]  <= fill_tag_i;
            data_q[fill_index_i] <= fill_block_i;
        end else if (wr_en_i) begin
            data_q[wr_index_i][wr_offset_i*WORD_W +: WORD_W] <= wr_word_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_block_o = data_q[rd_index_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with a 128-bit memory bus.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = DEFAULT_NUM_BLOCKS,
    parameter int unsigned ADDR_W     = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [BLOCK_W-1:0]  mem_wdata,
    input  logic [BLOCK_W-1:0]  mem_rdata,
    input  logic                mem_ready
);

    localparam int unsigned INDEX_W = $clog2(NUM_BLOCKS);
    localparam int unsigned TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

    state_e               state_q, state_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-3:0]    mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [INDEX_W-1:0]   index;
    logic [OFFSET_W-1:0]  offset;
    logic [TAG_W-1:0]     tag;
    logic                 req, hit;
    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [BLOCK_W-1:0]   rd_block;
    logic                 wr_en, fill_en;

    assign index  = proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign offset = proc_addr[OFFSET_W-1:0];
    assign tag    = proc_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign req    = proc_read | proc_write;
    assign hit    = rd_valid && (rd_tag == tag);

    cache_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .TAG_W      (TAG_W),
        .INDEX_W    (INDEX_W)
    ) u_store (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_index_i   (index),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_tag_o     (rd_tag),
        .rd_block_o   (rd_block),
        .wr_en_i      (wr_en),
        .wr_index_i   (index),
        .wr_offset_i  (offset),
        .wr_word_i    (proc_wdata),
        .fill_en_i    (fill_en),
        .fill_index_i (index),
        .fill_tag_i   (tag),
        .fill_block_i (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        proc_stall  = 1'b0;
        wr_en       = 1'b0;
        fill_en     = 1'b0;
        unique case (state_q)
            StCompare: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read+write request resolves as a write.
                        wr_en = proc_write;
                    end else begin
                        proc_stall = 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_d     = StWriteback;
                            mem_write_d = 1'b1;
                            mem_addr_d  = {rd_tag, index};
                            mem_wdata_d = rd_block;
                        end else begin
                            state_d    = StAllocate;
                            mem_read_d = 1'b1;
                            mem_addr_d = {tag, index};
                        end
                    end
                end
            end
            StWriteback: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d     = StAllocate;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {tag, index};
                end
            end
            StAllocate: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d    = StCompare;
                    fill_en    = 1'b1;
                    mem_read_d = 1'b0;
                end
            end
            default: state_d = StCompare;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCompare;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign proc_rdata = get_word(rd_block, offset);
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a transparent-memory reference model plus a latency-randomised memory.
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  data;
        bit           hit;
        bit           wb;
        logic [27:0]  wb_addr;
        logic [127:0] wb_data;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    bit slave_hold = 0;
    bit spur_en = 0;

    exp_t         sb [$];
    logic [27:0]  wb_addr_q [$];
    logic [127:0] wb_data_q [$];

    // CPU-visible memory image and the backing memory's own contents.
    logic [31:0]  ref_mem   [logic [29:0]];
    logic [127:0] slave_blk [logic [27:0]];

    // Reference cache occupancy used only to predict hit / writeback.
    bit           mvalid [8];
    bit           mdirty [8];
    logic [24:0]  mtag   [8];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {2'b0, a} * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [127:0] ref_line(input logic [27:0] b);
        return {ref_word({b, 2'd3}), ref_word({b, 2'd2}), ref_word({b, 2'd1}), ref_word({b, 2'd0})};
    endfunction

    function automatic logic [127:0] slave_get(input logic [27:0] b);
        if (slave_blk.exists(b)) return slave_blk[b];
        return {init_word({b, 2'd3}), init_word({b, 2'd2}), init_word({b, 2'd1}), init_word({b, 2'd0})};
    endfunction

    // After reset, dirty lines are lost: the CPU sees only what reached memory.
    task automatic model_reset();
        logic [127:0] blk;
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
        ref_mem.delete();
        foreach (slave_blk[b]) begin
            blk = slave_blk[b];
            for (int k = 0; k < 4; k++) ref_mem[{b, 2'(k)}] = blk[k*32 +: 32];
        end
        sb.delete();
        wb_addr_q.delete();
        wb_data_q.delete();
    endtask

    // Memory model: random latency, one-cycle mem_ready, optional spurious pulses when idle.
    initial begin
        int  wait_cnt;
        bit  busy;
        busy = 0;
        wait_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst) begin
                busy = 0;
                continue;
            end
            if (mem_read || mem_write) begin
                if (!busy) begin
                    busy = 1;
                    wait_cnt = $urandom_range(0, 3);
                end
                if (!slave_hold) begin
                    if (wait_cnt == 0) begin
                        if (mem_write) begin
                            slave_blk[mem_addr] = mem_wdata;
                            wb_addr_q.push_back(mem_addr);
                            wb_data_q.push_back(mem_wdata);
                        end else begin
                            mem_rdata = slave_get(mem_addr);
                        end
                        mem_ready = 1'b1;
                        busy = 0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor: completes a request when stall drops, compares against the queued expectation.
    always @(negedge clk) begin
        exp_t it;
        if (!rst) chk("mem_rw_exclusive", {126'b0, mem_read, mem_write} == 128'd3, 128'd0);
        if (rst || !(proc_read || proc_write)) begin
            cyc = 0;
        end else begin
            cyc++;
            if (!proc_stall) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 128'd0, 128'd1);
                end else begin
                    it = sb.pop_front();
                    chk("zero_wait_hit", {127'b0, cyc == 1}, {127'b0, it.hit});
                    if (!it.wr) chk("rdata", {96'b0, proc_rdata}, {96'b0, it.data});
                    chk("wb_count", 128'(wb_addr_q.size()), 128'(it.wb));
                    if (it.wb && wb_addr_q.size() > 0) begin
                        chk("wb_addr", {100'b0, wb_addr_q[0]}, {100'b0, it.wb_addr});
                        chk("wb_data", wb_data_q[0], it.wb_data);
                    end
                end
                wb_addr_q.delete();
                wb_data_q.delete();
                done_cnt++;
                cyc = 0;
            end
        end
    end

    task automatic do_reset();
        proc_read = 0;
        proc_write = 0;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        chk("rst_mem_read", {127'b0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'b0, mem_write}, 128'd0);
        chk("rst_mem_addr", {100'b0, mem_addr}, 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        chk("rst_stall", {127'b0, proc_stall}, 128'd0);
    endtask

    // Issue one access from just after a posedge; returns just after the completing posedge.
    task automatic do_access(input bit wr, input logic [29:0] a, input logic [31:0] d);
        exp_t        it;
        logic [2:0]  idx;
        logic [24:0] tg;
        int          target, n;
        idx = a[4:2];
        tg  = a[29:5];
        it.wr      = wr;
        it.hit     = mvalid[idx] && (mtag[idx] == tg);
        it.wb      = !it.hit && mvalid[idx] && mdirty[idx];
        it.wb_addr = {mtag[idx], idx};
        it.wb_data = ref_line({mtag[idx], idx});
        it.data    = ref_word(a);
        sb.push_back(it);
        if (wr) ref_mem[a] = d;
        mdirty[idx] = it.hit ? (mdirty[idx] | wr) : wr;
        mvalid[idx] = 1;
        mtag[idx]   = tg;

        proc_read  = !wr;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
        target = done_cnt + 1;
        @(posedge clk);
        #1;
        chk("first_mem_write", {127'b0, mem_write}, {127'b0, it.wb});
        chk("first_mem_read", {127'b0, mem_read}, {127'b0, !it.hit && !it.wb});
        if (!it.hit) chk("first_mem_addr", {100'b0, mem_addr},
                         {100'b0, it.wb ? it.wb_addr : {tg, idx}});
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt < target) begin
            chk("timeout", 128'd0, 128'd1);
            do_reset();
        end
        proc_read  = 0;
        proc_write = 0;
    endtask

    initial begin
        logic [29:0] a;
        rst = 1;
        proc_read = 0;
        proc_write = 0;
        proc_addr = '0;
        proc_wdata = '0;
        slave_blk[28'h4] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        do_reset();

        do_access(0, 30'h10, '0);                 // clean miss, fill block 4
        do_access(0, 30'h13, '0);                 // zero-wait hit, word 3
        do_access(1, 30'h11, 32'hDEADBEEF);       // write hit, line dirty
        do_access(0, 30'h11, '0);
        do_access(0, 30'h91, '0);                 // dirty eviction of block 4
        do_access(1, 30'h20, 32'hCAFEF00D);       // write miss on a clean line
        do_access(0, 30'h20, '0);

        // Abort an allocate with reset; the line must miss again afterwards.
        slave_hold = 1;
        proc_read = 1;
        proc_addr = 30'h210;
        @(posedge clk);
        #1;
        chk("abort_mem_read_up", {127'b0, mem_read}, 128'd1);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        chk("abort_mem_read_drop", {127'b0, mem_read}, 128'd0);
        chk("abort_mem_write_drop", {127'b0, mem_write}, 128'd0);
        proc_read = 0;
        rst = 0;
        slave_hold = 0;
        model_reset();
        do_access(0, 30'h210, '0);
        do_access(0, 30'h20, '0);

        spur_en = 1;
        for (int i = 0; i < 300; i++) begin
            a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        spur_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
